// File: rtl/memory_stage.sv
// Memory pipeline stage: EX/MEM register, req/ready data-memory access with a
// bounded wait counter and sticky timeout flag, and a registered MEM/WB bundle.
module memory_stage #(
    parameter int unsigned WIDTH   = 22,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_src_m,
    input  logic              reg_write_m,
    input  logic              mem_reg_m,
    input  logic              mem_write_m,
    input  logic [WIDTH-1:0]  alu_result_m,
    input  logic [WIDTH-1:0]  write_data_m,
    input  logic [3:0]        write_register_m,
    output logic              stall_m,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic              mem_ready,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic              pc_src_w,
    output logic              reg_write_w,
    output logic              mem_reg_w,
    output logic [WIDTH-1:0]  alu_result_w,
    output logic [WIDTH-1:0]  read_data_w,
    output logic [3:0]        write_register_w,
    output logic              mem_err
);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    logic             ex_pc_src;
    logic             ex_reg_write;
    logic             ex_mem_reg;
    logic             ex_mem_write;
    logic [WIDTH-1:0] ex_alu_result;
    logic [WIDTH-1:0] ex_write_data;
    logic [3:0]       ex_write_register;
    logic [CNT_W-1:0] wait_cnt;

    logic mem_op;
    logic is_load;
    logic timeout;
    logic complete;

    // Request side is decoded purely from the held EX/MEM contents and the counter.
    always_comb begin
        mem_op    = ex_mem_write | (ex_mem_reg & ex_reg_write);
        is_load   = ex_mem_reg & ex_reg_write & ~ex_mem_write;
        timeout   = (wait_cnt == CNT_MAX);
        mem_req   = mem_op;
        mem_we    = ex_mem_write;
        mem_addr  = ex_alu_result[ADDR_W-1:0];
        mem_wdata = ex_write_data;
        stall_m   = mem_op & ~mem_ready & ~timeout;
        complete  = mem_op & (mem_ready | timeout);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_pc_src         <= 1'b0;
            ex_reg_write      <= 1'b0;
            ex_mem_reg        <= 1'b0;
            ex_mem_write      <= 1'b0;
            ex_alu_result     <= '0;
            ex_write_data     <= '0;
            ex_write_register <= '0;
            wait_cnt          <= '0;
            mem_err           <= 1'b0;
            pc_src_w          <= 1'b0;
            reg_write_w       <= 1'b0;
            mem_reg_w         <= 1'b0;
            alu_result_w      <= '0;
            read_data_w       <= '0;
            write_register_w  <= '0;
        end else begin
            if (complete) begin
                wait_cnt <= '0;
            end else if (stall_m) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end

            // mem_ready wins over a coincident timeout.
            if (complete && !mem_ready) begin
                mem_err <= 1'b1;
            end

            if (stall_m) begin
                pc_src_w    <= 1'b0;
                reg_write_w <= 1'b0;
                mem_reg_w   <= 1'b0;
            end else begin
                ex_pc_src         <= pc_src_m;
                ex_reg_write      <= reg_write_m;
                ex_mem_reg        <= mem_reg_m;
                ex_mem_write      <= mem_write_m;
                ex_alu_result     <= alu_result_m;
                ex_write_data     <= write_data_m;
                ex_write_register <= write_register_m;
                pc_src_w          <= ex_pc_src;
                reg_write_w       <= ex_reg_write;
                mem_reg_w         <= ex_mem_reg;
                alu_result_w      <= ex_alu_result;
                write_register_w  <= ex_write_register;
                if (is_load) begin
                    read_data_w <= mem_ready ? mem_rdata : '0;
                end
            end
        end
    end
endmodule
